// File: rtl/fpu_cmd_issuer.sv
// Command issuer for the fpu: queues float32 commands, drives the fpu one
// operation at a time and returns tagged results over a valid/ready port.
module fpu_cmd_issuer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned FPU_LAT = 2,
   parameter int unsigned TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [1:0]       cmd_op,
   output logic [31:0]      fpu_a,
   output logic [31:0]      fpu_b,
   output logic [1:0]       fpu_op,
   input  logic [31:0]      fpu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned LAT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
   } cmd_t;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   cmd_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   cmd_t             head_c;
   logic             empty_c;
   logic             push_c;
   logic             pop_c;

   state_t           state;
   logic [LAT_W-1:0] lat_cnt;
   logic [TAG_W-1:0] issue_cnt;
   logic [TAG_W-1:0] cur_tag;

   assign empty_c   = (count == '0);
   assign cmd_ready = (count != CNT_W'(DEPTH));
   assign push_c    = cmd_valid && cmd_ready;
   assign head_c    = mem[rd_ptr];
   // The FSM pops exactly when it issues: from IDLE, or when a held result is taken.
   assign pop_c     = !empty_c && ((state == IDLE) || ((state == HOLD) && res_ready));
   assign busy      = !empty_c || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         issue_cnt <= '0;
         cur_tag   <= '0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         fpu_op    <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_tag   <= '0;
      end else begin
         case (state)
            IDLE: state <= IDLE;
            WAIT: begin
               if (lat_cnt != '0) begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end else begin
                  res_data  <= fpu_out;
                  res_tag   <= cur_tag;
                  res_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // An issue overrides the transition above (HOLD hand-off goes straight to WAIT).
         if (pop_c) begin
            fpu_a     <= head_c.a;
            fpu_b     <= head_c.b;
            fpu_op    <= head_c.op;
            lat_cnt   <= LAT_W'(FPU_LAT - 1);
            cur_tag   <= issue_cnt;
            issue_cnt <= issue_cnt + TAG_W'(1);
            state     <= WAIT;
         end
      end
   end

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Randomized self-checking bench for fpu_cmd_issuer with a stand-in fpu and
// a command-order scoreboard.
module tb_fpu_cmd_issuer;

   localparam int unsigned DEPTH   = 4;
   localparam int unsigned FPU_LAT = 2;
   localparam int unsigned TAG_W   = 4;

   logic             clk;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [31:0]      cmd_a;
   logic [31:0]      cmd_b;
   logic [1:0]       cmd_op;
   logic [31:0]      fpu_a;
   logic [31:0]      fpu_b;
   logic [1:0]       fpu_op;
   logic [31:0]      fpu_out;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;
   logic [TAG_W-1:0] res_tag;
   logic             busy;

   fpu_cmd_issuer #(.DEPTH(DEPTH), .FPU_LAT(FPU_LAT), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_out(fpu_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_tag(res_tag), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in fpu: known IEEE answers for 2.0 op 3.0, a scrambling function otherwise.
   function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
      if (a == 32'h4000_0000 && b == 32'h4040_0000) begin
         case (op)
            2'b00:   return 32'h40A0_0000;
            2'b01:   return 32'hBF80_0000;
            2'b10:   return 32'h40C0_0000;
            default: return 32'h3F2A_AAAB;
         endcase
      end
      return (a ^ {b[15:0], b[31:16]}) + (32'(op) * 32'h0100_0193);
   endfunction

   // Output is valid FPU_LAT-1 edges after the inputs settle, so the issuer's
   // capture edge (FPU_LAT edges after issue) sees the fresh value.
   logic [31:0] fpu_pipe [FPU_LAT-1];
   always @(posedge clk) begin
      fpu_pipe[0] <= fpu_fn(fpu_a, fpu_b, fpu_op);
      for (int i = 1; i < int'(FPU_LAT) - 1; i++) fpu_pipe[i] <= fpu_pipe[i-1];
   end
   assign fpu_out = fpu_pipe[FPU_LAT-2];

   typedef struct {
      logic [31:0]      a;
      logic [31:0]      b;
      logic [1:0]       op;
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   exp_t             exp_q[$];
   int               acc_cyc[$];
   int               cyc = 0;
   logic [TAG_W-1:0] tag_model;
   int               n_cmp = 0;
   int               n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: handshakes seen at the negedge take effect on the following posedge.
   logic        prev_valid;
   logic        prev_hs;
   logic [31:0] prev_data;
   logic [31:0] prev_tag;
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         tag_model  = '0;
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (prev_valid && !prev_hs) begin
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", res_data, prev_data);
            chk("hold_tag", 32'(res_tag), prev_tag);
         end
         if (res_valid) begin
            chk("result_has_cmd", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               chk("fpu_a_held", fpu_a, exp_q[0].a);
               chk("fpu_b_held", fpu_b, exp_q[0].b);
               chk("fpu_op_held", 32'(fpu_op), 32'(exp_q[0].op));
               if (res_ready) begin
                  chk("res_data", res_data, exp_q[0].data);
                  chk("res_tag", 32'(res_tag), 32'(exp_q[0].tag));
                  void'(exp_q.pop_front());
                  acc_cyc.push_back(cyc);
               end
            end
         end
         prev_valid = res_valid;
         prev_hs    = res_valid && res_ready;
         prev_data  = res_data;
         prev_tag   = 32'(res_tag);
         if (cmd_valid && cmd_ready) begin
            e.a = cmd_a; e.b = cmd_b; e.op = cmd_op;
            e.data = fpu_fn(cmd_a, cmd_b, cmd_op);
            e.tag = tag_model;
            tag_model = tag_model + TAG_W'(1);
            exp_q.push_back(e);
         end
      end
   end

   // Called and returns just after a posedge; the command is pushed on one edge.
   task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      int w = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("push_accept", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input int max);
      int w = 0;
      while ((exp_q.size() != 0 || busy) && w < max) begin
         @(posedge clk); #1;
         w++;
      end
      chk("drain_done", 32'(exp_q.size() != 0 || busy), 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_data"}, res_data, 32'd0);
      chk({tag, "_res_tag"}, 32'(res_tag), 32'd0);
      chk({tag, "_fpu_a"}, fpu_a, 32'd0);
      chk({tag, "_fpu_b"}, fpu_b, 32'd0);
      chk({tag, "_fpu_op"}, 32'(fpu_op), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 1ms", $time);
      $fatal(1);
   end

   initial begin
      int n0;
      int acc;
      int w;
      logic [31:0] sa, sb;
      logic [1:0]  sop;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_reset("por");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Single add: result visible exactly FPU_LAT+1 edges after the push edge.
      push_cmd(32'h4000_0000, 32'h4040_0000, 2'b00);
      for (int k = 1; k <= int'(FPU_LAT) + 1; k++) begin
         @(posedge clk); #1;
         chk($sformatf("lat_edge%0d", k), 32'(res_valid), 32'(k == int'(FPU_LAT) + 1));
      end
      chk("t1_data", res_data, 32'h40A0_0000);
      chk("t1_tag", 32'(res_tag), 32'd0);
      res_ready = 1'b1;
      drain(50);

      // Back-to-back sub/mul/div: one result every FPU_LAT+1 cycles.
      n0 = acc_cyc.size();
      push_cmd(32'h4000_0000, 32'h4040_0000, 2'b01);
      push_cmd(32'h4000_0000, 32'h4040_0000, 2'b10);
      push_cmd(32'h4000_0000, 32'h4040_0000, 2'b11);
      drain(50);
      chk("t2_count", 32'(acc_cyc.size() - n0), 32'd3);
      if (acc_cyc.size() >= n0 + 3) begin
         chk("t2_gap1", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'(FPU_LAT + 1));
         chk("t2_gap2", 32'(acc_cyc[n0+2] - acc_cyc[n0+1]), 32'(FPU_LAT + 1));
      end

      // Consumer stalled: FIFO fills to DEPTH plus one in flight, then back-pressure.
      res_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'($urandom); cmd_valid = 1'b1;
         @(negedge clk);
         if (cmd_ready) acc++;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      chk("t3_accepted", 32'(acc), 32'(DEPTH + 1));
      chk("t3_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("t3_busy", 32'(busy), 32'd1);
      res_ready = 1'b1;
      drain(200);

      // Tag wrap-around over 2^TAG_W+1 commands.
      for (int i = 0; i < (1 << TAG_W) + 1; i++) push_cmd($urandom, $urandom, 2'($urandom));
      drain(400);

      // Reset while waiting on the fpu.
      res_ready = 1'b0;
      push_cmd($urandom, $urandom, 2'b10);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1 chk_reset("rst_wait");
      @(negedge clk); @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset while holding a result.
      push_cmd($urandom, $urandom, 2'b11);
      repeat (FPU_LAT + 1) @(posedge clk);
      #1 chk("rst_hold_pre", 32'(res_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk_reset("rst_hold");
      @(negedge clk); @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      push_cmd(32'h4000_0000, 32'h4040_0000, 2'b10);
      w = 0;
      while (!res_valid && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      chk("post_rst_valid", 32'(res_valid), 32'd1);
      chk("post_rst_tag", 32'(res_tag), 32'd0);
      chk("post_rst_data", res_data, 32'h40C0_0000);
      res_ready = 1'b1;
      drain(50);

      // Idle with a toggling consumer: nothing moves.
      sa = fpu_a; sb = fpu_b; sop = fpu_op;
      for (int i = 0; i < 8; i++) begin
         res_ready = ~res_ready;
         @(posedge clk); #1;
         chk("idle_res_valid", 32'(res_valid), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
      end
      chk("idle_fpu_a", fpu_a, sa);
      chk("idle_fpu_b", fpu_b, sb);
      chk("idle_fpu_op", 32'(fpu_op), 32'(sop));

      // Random traffic on both ports.
      for (int i = 0; i < 600; i++) begin
         cmd_valid = ($urandom_range(0, 99) < 55);
         cmd_a = $urandom; cmd_b = $urandom; cmd_op = 2'($urandom);
         res_ready = ($urandom_range(0, 99) < 60);
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      drain(500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
